// File: rtl/antidiff_seq_pkg.sv
// antidiff_seq_pkg
//   Shared types and default sizing for the antidiff sequencer.
//   - state_t   : sequencer FSM states
//   - sample_t  : one signed sample at the default width
//   - TMR_W     : timer width large enough for the watchdog terminal count
//   - clamp_order(): limits a requested order to the largest accepted order
package antidiff_seq_pkg;

  localparam int SEQ_LEN        = 19;
  localparam int SEQ_WIDTH      = 16;
  localparam int SEQ_ORDER_MAX  = 4;
  localparam int SEQ_OP_LATENCY = 88;
  localparam int TMR_W          = $clog2(4*SEQ_OP_LATENCY+1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, STORE, FIN} state_t;

  typedef logic signed [SEQ_WIDTH-1:0] sample_t;

  function automatic logic [2:0] clamp_order(input logic [2:0] o, input int omax);
    return (int'(o) > omax) ? 3'(omax) : o;
  endfunction

endpackage

// File: rtl/antidiff_sequencer_if.sv
// antidiff_sequencer_if
//   Bundle between the sequencer and the external antidiff_operator_multi.
//   - op_en   : 1-cycle enable pulse, sequencer -> operator
//   - op_in   : registered operand vector, sequencer -> operator
//   - op_out  : operator result vector, operator -> sequencer
//   - op_done : completion strobe, operator -> sequencer
//               (only present with ANTIDIFF_SEQ_DONE_HS_EN defined)
//   master = sequencer side, slave = operator side.
interface antidiff_sequencer_if #(
  parameter int LEN   = 19,
  parameter int WIDTH = 16
);
  logic                        op_en;
  logic [LEN-1:0][WIDTH-1:0]   op_in;
  logic [LEN-1:0][WIDTH-1:0]   op_out;
`ifdef ANTIDIFF_SEQ_DONE_HS_EN
  logic                        op_done;

  modport master (output op_en, output op_in, input  op_out, input  op_done);
  modport slave  (input  op_en, input  op_in, output op_out, output op_done);
`else
  modport master (output op_en, output op_in, input  op_out);
  modport slave  (input  op_en, input  op_in, output op_out);
`endif
endinterface

// File: rtl/antidiff_seq_timer.sv
// antidiff_seq_timer
//   Clear/enable up-counter with a terminal-count compare. Used for the
//   fixed operator latency and, in handshake builds, as the watchdog.
//   - clk, reset : clock, async active-low reset
//   - clr        : synchronous clear to zero (wins over en)
//   - en         : count enable
//   - term       : terminal count value
//   - tc         : high while enabled and the count equals term
module antidiff_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  // Saturates at term so a missed tc can never wrap into a false match.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (en && cnt_q != term) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = en && (cnt_q == term);

endmodule

// File: rtl/antidiff_sequencer.sv
// antidiff_sequencer
//   Runs the external antidiff operator ORDER times back to back for N-th
//   order recovery: loads vec_in as the first operand, pulses op_en, waits
//   out each pass, feeds op_out back as the next operand, and publishes the
//   final operand on vec_out with a done pulse. Samples pass through
//   bit-exact.
//   Ports:
//   - clk, reset : clock, async active-low reset
//   - start      : 1-cycle request, honoured only in IDLE
//   - order      : requested pass count (clamped to ORDER_MAX)
//   - vec_in     : input vector, read while loading
//   - busy       : high from accepted start until done
//   - done       : 1-cycle pulse, vec_out valid from this cycle on
//   - order_err  : requested order too large (or watchdog timeout); sticky
//                  until the next accepted start
//   - pass_cnt   : passes completed in the current job
//   - vec_out    : result vector, held until the next done
//   - op         : operator bundle (master side)
//   Build option ANTIDIFF_SEQ_DONE_HS_EN: passes end on op.op_done and the
//   timer acts as a 4*OP_LATENCY watchdog that aborts the job to FIN.
module antidiff_sequencer
  import antidiff_seq_pkg::*;
#(
  parameter int LEN        = SEQ_LEN,
  parameter int WIDTH      = SEQ_WIDTH,
  parameter int ORDER_MAX  = SEQ_ORDER_MAX,
  parameter int OP_LATENCY = SEQ_OP_LATENCY
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [2:0]                order,
  input  logic [LEN-1:0][WIDTH-1:0] vec_in,
  output logic                      busy,
  output logic                      done,
  output logic                      order_err,
  output logic [2:0]                pass_cnt,
  output logic [LEN-1:0][WIDTH-1:0] vec_out,
  antidiff_sequencer_if.master      op
);

  localparam int TW = $clog2(4*OP_LATENCY+1);
`ifdef ANTIDIFF_SEQ_DONE_HS_EN
  localparam logic [TW-1:0] TERM = TW'(4*OP_LATENCY-1);
`else
  localparam logic [TW-1:0] TERM = TW'(OP_LATENCY-1);
`endif

  state_t                    state_q, state_d;
  logic [2:0]                ord_q, ord_d;
  logic [2:0]                pass_q, pass_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      op_en_q, op_en_d;
  logic [LEN-1:0][WIDTH-1:0] op_in_q, op_in_d;
  logic [LEN-1:0][WIDTH-1:0] vec_out_q, vec_out_d;

  logic tmr_clr, tmr_en, tmr_tc;

  antidiff_seq_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .term  (TERM),
    .tc    (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    ord_d     = ord_q;
    pass_d    = pass_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    op_en_d   = 1'b0;
    op_in_d   = op_in_q;
    vec_out_d = vec_out_q;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ord_d   = clamp_order(order, ORDER_MAX);
          err_d   = (int'(order) > ORDER_MAX);
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        op_in_d = vec_in;
        pass_d  = '0;
        if (ord_q == '0) begin
          state_d = FIN;
        end else begin
          // op_en is registered, so raise it on the way into START
          op_en_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tmr_clr = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        tmr_en = 1'b1;
`ifdef ANTIDIFF_SEQ_DONE_HS_EN
        if (op.op_done) begin
          state_d = STORE;
        end else if (tmr_tc) begin
          // operator never answered: flag it and publish the current operand
          err_d   = 1'b1;
          state_d = FIN;
        end
`else
        if (tmr_tc) state_d = STORE;
`endif
      end
      STORE: begin
        op_in_d = op.op_out;
        pass_d  = 3'(pass_q + 3'd1);
        if (3'(pass_q + 3'd1) == ord_q) begin
          state_d = FIN;
        end else begin
          op_en_d = 1'b1;
          state_d = START;
        end
      end
      FIN: begin
        vec_out_d = op_in_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ord_q     <= '0;
      pass_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      op_en_q   <= 1'b0;
      op_in_q   <= '0;
      vec_out_q <= '0;
    end else begin
      state_q   <= state_d;
      ord_q     <= ord_d;
      pass_q    <= pass_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      op_en_q   <= op_en_d;
      op_in_q   <= op_in_d;
      vec_out_q <= vec_out_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign order_err = err_q;
  assign pass_cnt  = pass_q;
  assign vec_out   = vec_out_q;
  assign op.op_en  = op_en_q;
  assign op.op_in  = op_in_q;

endmodule

// File: tb/tb_antidiff_sequencer.sv
module tb_antidiff_sequencer;
  localparam int LEN = 19;
  localparam int W   = 16;
  localparam int LAT = 4;
  localparam int OMAX = 4;
`ifdef ANTIDIFF_SEQ_DONE_HS_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif
  typedef logic [LEN-1:0][W-1:0] vec_t;

  logic       clk = 1'b0, reset = 1'b0, start = 1'b0, mute = 1'b0;
  logic [2:0] order = '0;
  vec_t       vec_in = '0;
  logic       busy, done, order_err;
  logic [2:0] pass_cnt;
  vec_t       vec_out;
  int         n_chk = 0, n_fail = 0;

  antidiff_sequencer_if #(.LEN(LEN), .WIDTH(W)) opif();

  antidiff_sequencer #(.LEN(LEN), .WIDTH(W), .ORDER_MAX(OMAX), .OP_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .order(order), .vec_in(vec_in),
    .busy(busy), .done(done), .order_err(order_err), .pass_cnt(pass_cnt),
    .vec_out(vec_out), .op(opif)
  );

  always #5 clk = ~clk;

  function automatic vec_t psum(input vec_t v);
    vec_t r;
    int acc = 0;
    for (int i = 0; i < LEN; i++) begin
      acc += int'($signed(v[i]));
      r[i] = W'(acc);
    end
    return r;
  endfunction

  function automatic vec_t recover(input vec_t v, input int passes);
    vec_t r = v;
    for (int p = 0; p < passes; p++) r = psum(r);
    return r;
  endfunction

  function automatic vec_t to_vec(input int a [LEN]);
    vec_t r;
    for (int i = 0; i < LEN; i++) r[i] = W'(a[i]);
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input vec_t act, input vec_t exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Stub operator: inclusive prefix sum, result ready within LAT cycles,
  // op_done strobed LAT cycles after op_en in handshake builds.
  logic [3:0] en_sr = '0;
  always @(posedge clk) begin
    if (opif.op_en) opif.op_out <= psum(opif.op_in);
    en_sr <= {en_sr[2:0], opif.op_en};
  end
`ifdef ANTIDIFF_SEQ_DONE_HS_EN
  assign opif.op_done = en_sr[3] & ~mute;
`endif

  int en_cnt = 0;
  always @(negedge clk) if (opif.op_en) en_cnt <= en_cnt + 1;

  // Job-level model: accepted start at edge s gives done after edge
  // s+latency-1, result = operator applied ord times.
  int   ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  logic m_active = 1'b0, m_err = 1'b0, m_mute = 1'b0;
  int   m_s = 0, m_done_e = 0, m_pulses = 0, m_pass = 0;
  vec_t m_exp = '0, m_hold = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_err    <= 1'b0;
      m_hold   <= '0;
    end else begin
      if (m_active && ecnt == m_done_e) m_hold <= m_exp;
      if (m_active && m_mute && ecnt == m_done_e - 1) m_err <= 1'b1;
      if (start && (!m_active || ecnt > m_done_e)) begin
        m_active <= 1'b1;
        m_s      <= ecnt;
        m_mute   <= HS && mute;
        m_err    <= (int'(order) > OMAX);
        if (HS && mute) begin
          m_done_e <= ecnt + 3 + 1 + 4*LAT - 1;
          m_exp    <= vec_in;
          m_pulses <= 1;
          m_pass   <= 0;
        end else begin
          m_done_e <= ecnt + 3 + ((int'(order) > OMAX) ? OMAX : int'(order)) * (LAT+2) - 1;
          m_exp    <= recover(vec_in, (int'(order) > OMAX) ? OMAX : int'(order));
          m_pulses <= (int'(order) > OMAX) ? OMAX : int'(order);
          m_pass   <= (int'(order) > OMAX) ? OMAX : int'(order);
        end
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    int k, j;
    bit eb, ed, eo;
    if (chk_en) begin
      k  = ecnt - 1;
      j  = k - m_s - 1;
      eb = m_active && (k < m_done_e);
      ed = m_active && (k == m_done_e);
      eo = eb && (j >= 0) && (j % (LAT+2) == 0) && (j / (LAT+2) < m_pulses);
      chk("busy", busy, eb);
      chk("done", done, ed);
      chk("op_en", opif.op_en, eo);
      chk("order_err", order_err, m_err);
      chkv("vec_out", vec_out, m_hold);
      if (ed) chk("pass_cnt_at_done", pass_cnt, m_pass);
    end
  end

  task automatic run_job(input int ord, input vec_t v, output int n, output int pulses);
    int c0;
    @(posedge clk); #1;
    order = 3'(ord); vec_in = v; start = 1'b1; c0 = en_cnt;
    @(posedge clk); #1;
    start = 1'b0; n = 1;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", done, 1);
    pulses = en_cnt - c0;
  endtask

  initial begin
    int   n, p, nd, nfirst, c0;
    int   a_v  [LEN] = '{0,0,-8,8,-8,8,-8,0,16,-24,16,0,-16,0,0,0,0,0,0};
    int   a_e1 [LEN] = '{0,0,-8,0,-8,0,-8,-8,8,-16,0,0,-16,-16,-16,-16,-16,-16,-16};
    vec_t v, e1, r;
    v  = to_vec(a_v);
    e1 = to_vec(a_e1);
    for (int i = 0; i < LEN; i++) r[i] = W'($urandom_range(0, 65535));

    repeat (2) @(posedge clk); #1;
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_op_en", opif.op_en, 0);
    chk("rst_err", order_err, 0);
    chk("rst_pass", pass_cnt, 0);
    chkv("rst_vec_out", vec_out, '0);
    chkv("rst_op_in", opif.op_in, '0);
    @(posedge clk); #1;
    reset = 1'b1;

    run_job(1, v, n, p);
    chk("o1_lat", n, 9);
    chkv("o1_vec", vec_out, e1);
    chk("o1_pass", pass_cnt, 1);
    chk("o1_pulses", p, 1);

    run_job(2, v, n, p);
    chk("o2_lat", n, 15);
    chk("o2_pulses", p, 2);
    chk("o2_v2", $signed(vec_out[2]), -8);
    chk("o2_v3", $signed(vec_out[3]), -8);
    chk("o2_v4", $signed(vec_out[4]), -16);

    run_job(0, r, n, p);
    chk("o0_lat", n, 3);
    chkv("o0_vec", vec_out, r);
    chk("o0_pulses", p, 0);

    run_job(7, r, n, p);
    chk("o7_lat", n, 3 + 4*6);
    chk("o7_err", order_err, 1);
    chk("o7_pass", pass_cnt, 4);
    chk("o7_pulses", p, 4);

    // start held high for the whole job
    @(posedge clk); #1;
    order = 3'd1; vec_in = v; start = 1'b1; c0 = en_cnt; n = 0; nd = 0; nfirst = 0;
    repeat (30) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        nd++;
        if (nfirst == 0) nfirst = n;
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("bs_dones", nd, 1);
    chk("bs_lat", nfirst, 9);
    chkv("bs_vec", vec_out, e1);
    chk("bs_pulses", en_cnt - c0, 1);
    chk("bs_err_cleared", order_err, 0);

    // asynchronous reset in the middle of WAIT
    @(posedge clk); #1;
    order = 3'd2; vec_in = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("mid_busy_before", busy, 1);
    reset = 1'b0; #1;
    chk("mid_busy", busy, 0);
    chk("mid_op_en", opif.op_en, 0);
    chkv("mid_vec_out", vec_out, '0);
    chk("mid_pass", pass_cnt, 0);
    repeat (6) @(posedge clk); #1;
    reset = 1'b1;
    run_job(1, v, n, p);
    chk("post_rst_lat", n, 9);
    chkv("post_rst_vec", vec_out, e1);

`ifdef ANTIDIFF_SEQ_DONE_HS_EN
    mute = 1'b1;
    run_job(1, v, n, p);
    mute = 1'b0;
    chk("wd_lat", n, 3 + 1 + 4*LAT);
    chk("wd_err", order_err, 1);
    chkv("wd_vec", vec_out, v);
    chk("wd_pass", pass_cnt, 0);
`endif

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
